// File: rtl/sysid_checker_pkg.sv
// sysid_checker_pkg: checker FSM states, CSR word addresses and status bit positions
package sysid_checker_pkg;
  typedef enum logic [2:0] {IDLE, RD_ID, WAIT_ID, RD_TS, WAIT_TS, COMPARE, DONE} state_e;
  localparam logic [1:0] CSR_STATUS = 2'd0;
  localparam logic [1:0] CSR_ID = 2'd1;
  localparam logic [1:0] CSR_TS = 2'd2;
  localparam logic [1:0] CSR_CTRL = 2'd3;
  localparam int ST_DONE = 0;
  localparam int ST_ID_OK = 1;
  localparam int ST_TS_OK = 2;
  localparam int ST_BUSY = 3;
endpackage

// File: rtl/sysid_checker_csr.sv
// sysid_checker_csr: CSR decode with registered readdata and restart pulse, accepted only once a verdict exists
module sysid_checker_csr
  import sysid_checker_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic [1:0]  csr_address,
  input  logic        csr_read,
  input  logic        csr_write,
  input  logic [31:0] csr_writedata,
  input  logic        busy,
  input  logic        check_done,
  input  logic        id_ok,
  input  logic        ts_ok,
  input  logic [31:0] id,
  input  logic [31:0] ts,
  input  logic [7:0]  pass_count,
  output logic [31:0] csr_readdata,
  output logic        restart
);
  logic [3:0] status;
  logic [31:0] rdata_d, rdata_q;
  logic unused_wdata;
  always_comb begin
    status = '0;
    status[ST_DONE] = check_done;
    status[ST_ID_OK] = id_ok;
    status[ST_TS_OK] = ts_ok;
    status[ST_BUSY] = busy;
    rdata_d = !csr_read ? rdata_q :
              csr_address == CSR_STATUS ? {28'b0, status} :
              csr_address == CSR_ID ? id :
              csr_address == CSR_TS ? ts : {24'b0, pass_count};
  end
  always_ff @(posedge clock) rdata_q <= !reset_n ? '0 : rdata_d;
  assign restart = csr_write && csr_address == CSR_CTRL && csr_writedata[0] && check_done;
  assign csr_readdata = rdata_q;
  assign unused_wdata = ^csr_writedata[31:1];
endmodule

// File: rtl/sysid_boot_checker.sv
// sysid_boot_checker: post-reset sysid ID/timestamp verifier with CSR status; SYSID_CHECKER_RETRY_EN enables retry passes on mismatch
module sysid_boot_checker
  import sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1363592293,
  parameter int RD_LATENCY = 0,
  parameter int MAX_RETRY = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        sysid_address,
  output logic        sysid_read,
  input  logic [31:0] sysid_readdata,
  input  logic [1:0]  csr_address,
  input  logic        csr_read,
  input  logic        csr_write,
  input  logic [31:0] csr_writedata,
  output logic [31:0] csr_readdata,
  output logic        check_done,
  output logic        check_match
);
  localparam logic [1:0] LAST = 2'(RD_LATENCY - 1);
`ifdef SYSID_CHECKER_RETRY_EN
  localparam logic [2:0] RETRIES = 3'(MAX_RETRY);
`else
  localparam logic [2:0] RETRIES = 3'(MAX_RETRY) & 3'd0;
`endif
  state_e state_d, state_q;
  logic [1:0] cnt_d, cnt_q;
  logic [31:0] id_d, id_q, ts_d, ts_q;
  logic [7:0] pc_d, pc_q;
  logic [2:0] retry_d, retry_q;
  logic id_ok_d, id_ok_q, ts_ok_d, ts_ok_q, done_d, done_q, match_d, match_q;
  logic id_hit, ts_hit, busy, restart;
  assign id_hit = id_q == EXPECTED_ID;
  assign ts_hit = ts_q == EXPECTED_TIMESTAMP;
  assign busy = state_q != IDLE && state_q != DONE;
  always_comb begin
    state_d = state_q;
    cnt_d = '0;
    id_d = id_q;
    ts_d = ts_q;
    retry_d = retry_q;
    id_ok_d = id_ok_q;
    ts_ok_d = ts_ok_q;
    done_d = done_q;
    match_d = match_q;
    sysid_read = 1'b0;
    sysid_address = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = RD_ID;
        retry_d = '0;
      end
      RD_ID: begin
        sysid_read = 1'b1;
        id_d = RD_LATENCY == 0 ? sysid_readdata : id_q;
        state_d = RD_LATENCY == 0 ? RD_TS : WAIT_ID;
      end
      WAIT_ID: begin
        cnt_d = cnt_q + 2'd1;
        id_d = cnt_q == LAST ? sysid_readdata : id_q;
        state_d = cnt_q == LAST ? RD_TS : WAIT_ID;
      end
      RD_TS: begin
        sysid_read = 1'b1;
        sysid_address = 1'b1;
        ts_d = RD_LATENCY == 0 ? sysid_readdata : ts_q;
        state_d = RD_LATENCY == 0 ? COMPARE : WAIT_TS;
      end
      WAIT_TS: begin
        cnt_d = cnt_q + 2'd1;
        ts_d = cnt_q == LAST ? sysid_readdata : ts_q;
        state_d = cnt_q == LAST ? COMPARE : WAIT_TS;
      end
      COMPARE: begin
        if ((id_hit && ts_hit) || retry_q == RETRIES) begin
          id_ok_d = id_hit;
          ts_ok_d = ts_hit;
          done_d = 1'b1;
          match_d = id_hit && ts_hit;
          state_d = DONE;
        end else begin
          retry_d = retry_q + 3'd1;
          state_d = RD_ID;
        end
      end
      DONE: begin
        if (restart) begin
          id_ok_d = 1'b0;
          ts_ok_d = 1'b0;
          done_d = 1'b0;
          match_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    pc_d = state_d == COMPARE && pc_q != 8'hff ? pc_q + 8'd1 : pc_q;
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      id_q <= '0;
      ts_q <= '0;
      pc_q <= '0;
      retry_q <= '0;
      id_ok_q <= 1'b0;
      ts_ok_q <= 1'b0;
      done_q <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      id_q <= id_d;
      ts_q <= ts_d;
      pc_q <= pc_d;
      retry_q <= retry_d;
      id_ok_q <= id_ok_d;
      ts_ok_q <= ts_ok_d;
      done_q <= done_d;
      match_q <= match_d;
    end
  end
  assign check_done = done_q;
  assign check_match = match_q;
  sysid_checker_csr u_csr (
    .clock(clock),
    .reset_n(reset_n),
    .csr_address(csr_address),
    .csr_read(csr_read),
    .csr_write(csr_write),
    .csr_writedata(csr_writedata),
    .busy(busy),
    .check_done(done_q),
    .id_ok(id_ok_q),
    .ts_ok(ts_ok_q),
    .id(id_q),
    .ts(ts_q),
    .pass_count(pc_q),
    .csr_readdata(csr_readdata),
    .restart(restart)
  );
endmodule

// File: tb/tb_sysid_boot_checker.sv
// tb_sysid_boot_checker: randomized bench running sysid_boot_checker at read latencies 0 and 2 against a pass-level model
module tb_sysid_boot_checker;
  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1363592293;
`ifdef SYSID_CHECKER_RETRY_EN
  localparam int R = 3;
`else
  localparam int R = 0;
`endif
  logic clock = 1'b0;
  logic reset_n;
  logic [1:0] csr_address;
  logic csr_read, csr_write;
  logic [31:0] csr_writedata;
  logic [1:0] rd, ad, done, match;
  logic [31:0] rdat [2];
  logic [31:0] crd [2];
  int id_cnt [2];
  int base [2];
  logic [31:0] junk;
  logic p1v, p2v;
  logic [31:0] p1d, p2d;
  int good_from;
  logic [31:0] bad_id, bad_ts;
  int pc_exp;
  int n_vec, n_bad;

  always #5 clock = ~clock;

  sysid_boot_checker #(.RD_LATENCY(0)) dut0 (
    .clock(clock), .reset_n(reset_n),
    .sysid_address(ad[0]), .sysid_read(rd[0]), .sysid_readdata(rdat[0]),
    .csr_address(csr_address), .csr_read(csr_read), .csr_write(csr_write),
    .csr_writedata(csr_writedata), .csr_readdata(crd[0]),
    .check_done(done[0]), .check_match(match[0])
  );
  sysid_boot_checker #(.RD_LATENCY(2)) dut1 (
    .clock(clock), .reset_n(reset_n),
    .sysid_address(ad[1]), .sysid_read(rd[1]), .sysid_readdata(rdat[1]),
    .csr_address(csr_address), .csr_read(csr_read), .csr_write(csr_write),
    .csr_writedata(csr_writedata), .csr_readdata(crd[1]),
    .check_done(done[1]), .check_match(match[1])
  );

  function automatic int lat(input int i);
    return 2 * i;
  endfunction

  // word the slave returns on pass p (0-based within the current run)
  function automatic logic [31:0] val(input logic a, input int p);
    return p >= good_from ? (a ? EXP_TS : EXP_ID) : (a ? bad_ts : bad_id);
  endfunction

  function automatic int pidx(input int i, input logic a);
    return id_cnt[i] - base[i] - (a ? 1 : 0);
  endfunction

  always @(posedge clock) begin
    junk <= $urandom;
    for (int i = 0; i < 2; i++) if (rd[i] && !ad[i]) id_cnt[i] <= id_cnt[i] + 1;
    p1v <= rd[1];
    p1d <= val(ad[1], pidx(1, ad[1]));
    p2v <= p1v;
    p2d <= p1d;
  end

  always_comb begin
    rdat[0] = rd[0] ? val(ad[0], pidx(0, ad[0])) : junk;
    rdat[1] = p2v ? p2d : junk;
  end

  task automatic run_pass(input string tag, input bit busy_wr);
    int pf, per, d, k;
    logic hit, erd, ead, edn, emt, id_ok, ts_ok;
    logic [31:0] exp;
    pf = R;
    for (int p = R; p >= 0; p--) if (val(1'b0, p) == EXP_ID && val(1'b1, p) == EXP_TS) pf = p;
    id_ok = val(1'b0, pf) == EXP_ID;
    ts_ok = val(1'b1, pf) == EXP_TS;
    hit = id_ok && ts_ok;
    for (int i = 0; i < 2; i++) base[i] = id_cnt[i];
    csr_address = 2'd3;
    csr_writedata = 32'd1;
    for (int e = 1; e <= 5 + 2 * lat(1) + pf * (3 + 2 * lat(1)); e++) begin
      @(negedge clock);
      csr_write = busy_wr && e == 2;
      for (int i = 0; i < 2; i++) begin
        per = 3 + 2 * lat(i);
        d = 4 + 2 * lat(i) + pf * per;
        k = e - 1;
        erd = k / per <= pf && (k % per == 0 || k % per == 1 + lat(i));
        ead = erd && k % per == 1 + lat(i);
        edn = e >= d;
        emt = edn && hit;
        n_vec++;
        if (rd[i] !== erd || ad[i] !== ead) begin
          n_bad++;
          $display("FAIL %s read/addr dut%0d edge %0d: got %b/%b want %b/%b", tag, i, e, rd[i], ad[i], erd, ead);
        end
        n_vec++;
        if (done[i] !== edn || match[i] !== emt) begin
          n_bad++;
          $display("FAIL %s done/match dut%0d edge %0d: got %b/%b want %b/%b", tag, i, e, done[i], match[i], edn, emt);
        end
      end
    end
    pc_exp = pc_exp + pf + 1 > 255 ? 255 : pc_exp + pf + 1;
    for (int a = 0; a < 4; a++) begin
      csr_address = 2'(a);
      csr_read = 1'b1;
      @(negedge clock);
      csr_read = 1'b0;
      exp = a == 0 ? {28'b0, 1'b0, ts_ok, id_ok, 1'b1} : a == 1 ? val(1'b0, pf) : a == 2 ? val(1'b1, pf) : 32'(pc_exp);
      for (int i = 0; i < 2; i++) begin
        n_vec++;
        if (crd[i] !== exp) begin
          n_bad++;
          $display("FAIL %s csr%0d dut%0d: got %h want %h", tag, a, i, crd[i], exp);
        end
      end
    end
  endtask

  task automatic do_restart(input string tag);
    csr_address = 2'd3;
    csr_writedata = $urandom | 32'd1;
    csr_write = 1'b1;
    csr_read = 1'b1;
    @(negedge clock);
    csr_write = 1'b0;
    csr_read = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (done[i] !== 1'b0 || match[i] !== 1'b0 || crd[i] !== 32'(pc_exp)) begin
        n_bad++;
        $display("FAIL %s restart dut%0d: done/match/rdata %b/%b/%h want 0/0/%h", tag, i, done[i], match[i], crd[i], pc_exp);
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if ({rd[i], ad[i], done[i], match[i]} !== 4'b0 || crd[i] !== 32'd0) begin
        n_bad++;
        $display("FAIL reset dut%0d: rd/ad/done/match %b%b%b%b rdata %h want 0000/0", i, rd[i], ad[i], done[i], match[i], crd[i]);
      end
    end
    reset_n = 1'b1;
    pc_exp = 0;
  endtask

  task automatic test_match;
    good_from = 0;
    run_pass("match", 1'b0);
  endtask

  task automatic test_ignored_writes;
    for (int a = 0; a < 4; a++) begin
      csr_address = 2'(a);
      csr_writedata = a == 3 ? $urandom & ~32'd1 : $urandom | 32'd1;
      csr_write = 1'b1;
      @(negedge clock);
    end
    csr_write = 1'b0;
    repeat (2) @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (done[i] !== 1'b1 || rd[i] !== 1'b0) begin
        n_bad++;
        $display("FAIL ignored_writes dut%0d: done/read %b/%b want 1/0", i, done[i], rd[i]);
      end
    end
  endtask

  task automatic test_id_mismatch;
    good_from = 1000;
    bad_id = 32'd5;
    bad_ts = EXP_TS;
    do_restart("id_mismatch");
    run_pass("id_mismatch", 1'b1);
  endtask

  task automatic test_retry;
    good_from = 2;
    bad_id = $urandom | 32'd1;
    bad_ts = $urandom;
    do_restart("retry");
    run_pass("retry", 1'b0);
  endtask

  task automatic test_random;
    for (int t = 0; t < 8; t++) begin
      good_from = int'($urandom_range(0, R + 1));
      bad_id = $urandom_range(0, 1) ? EXP_ID : 32'($urandom);
      bad_ts = $urandom_range(0, 1) ? EXP_TS : 32'($urandom);
      do_restart("random");
      run_pass("random", 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid;
    do_restart("reset_mid");
    repeat (5) @(negedge clock);
    n_vec++;
    if (done[1] !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid busy dut1: done %b want 0", done[1]);
    end
    reset_n = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if ({rd[i], ad[i], done[i], match[i]} !== 4'b0 || crd[i] !== 32'd0) begin
        n_bad++;
        $display("FAIL reset_mid dut%0d: rd/ad/done/match %b%b%b%b rdata %h want 0000/0", i, rd[i], ad[i], done[i], match[i], crd[i]);
      end
    end
    @(negedge clock);
    reset_n = 1'b1;
    pc_exp = 0;
    good_from = 0;
    run_pass("after_reset", 1'b0);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset_n = 1'b0;
    csr_address = '0;
    csr_read = 1'b0;
    csr_write = 1'b0;
    csr_writedata = '0;
    good_from = 0;
    bad_id = '0;
    bad_ts = '0;
    pc_exp = 0;
    test_reset;
    test_match;
    test_ignored_writes;
    test_id_mismatch;
    test_retry;
    test_random;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/sysid_boot_checker.md
# sysid_boot_checker

Post-reset verifier for the system-ID slave. After reset it acts as a small Avalon-MM read master on the sysid control slave. It reads the ID word (address 0) and the timestamp word (address 1), then compares both against expected values fixed at build time. Results go to two status pins and to a 4-word CSR slave, so the Nios II or bring-up logic can confirm it is running on the intended hardware image before software boots.

## Interface
- EXPECTED_ID, 32'd0: expected word at sysid address 0
- EXPECTED_TIMESTAMP, 32'd1363592293: expected word at sysid address 1
- RD_LATENCY, 0: cycles from read-command cycle to valid sysid_readdata; legal 0..3 (0 = combinational slave)
- MAX_RETRY, 3: extra passes after a mismatch; legal 1..7; used only with SYSID_CHECKER_RETRY_EN
- clock  in  1  single system clock, rising edge
- reset_n  in  1  reset; synchronous, active-low
- sysid_address  out  1  word address to the sysid slave
- sysid_read  out  1  read strobe, one cycle per access
- sysid_readdata  in  32  sysid read data
- csr_address  in  2  CSR word address
- csr_read  in  1  CSR read strobe
- csr_write  in  1  CSR write strobe
- csr_writedata  in  32  CSR write data
- csr_readdata  out  32  CSR read data, registered
- check_done  out  1  high once a final verdict exists
- check_match  out  1  high when the final verdict is ID and timestamp both matching

## Operation
- FSM states: IDLE, RD_ID, WAIT_ID, RD_TS, WAIT_TS, COMPARE, DONE.
- IDLE: entered on reset. Leaves to RD_ID on the first clock after reset, and on a restart request.
- RD_ID: sysid_read=1, sysid_address=0.
  - If RD_LATENCY=0, captures readdata into id_q and goes to RD_TS.
  - Otherwise goes to WAIT_ID.
- WAIT_ID: counts RD_LATENCY cycles and captures id_q on the last one. sysid_read=0.
- RD_TS / WAIT_TS: same as RD_ID / WAIT_ID, with address 1, capturing ts_q.
- COMPARE:
  - id_ok = (id_q == EXPECTED_ID); ts_ok = (ts_q == EXPECTED_TIMESTAMP).
  - Final verdict, or retry (see Configuration). On a final verdict goes to DONE.
- DONE: check_done=1, check_match=id_ok&ts_ok. Holds until a restart request.
- In every state other than RD_ID/RD_TS, sysid_read=0 and sysid_address=0.
- CSR map. Reads are registered: data appears on csr_readdata the cycle after csr_read.
  - Address 0: {28'b0, busy, ts_ok, id_ok, check_done}. busy = state not IDLE/DONE.
  - Address 1: id_q.
  - Address 2: ts_q.
  - Address 3 read: {24'b0, pass_count}. pass_count is 8 bits, saturates at 255, and increments on every entry to COMPARE.
  - Address 3 write with writedata[0]=1: restart. Accepted only in DONE; ignored while busy.
  - Writes to addresses 0..2 are ignored.
- Restart:
  - Clears check_done, check_match, id_ok and ts_ok in the cycle the FSM leaves DONE.
  - Does not clear id_q, ts_q or pass_count.
- csr_read and csr_write in the same cycle: the write takes effect and the read returns pre-write state.
- Reset mid-check aborts immediately. All registers return to reset values and the check restarts after reset release.

## Timing
- Reset values: sysid_read=0, sysid_address=0, csr_readdata=0, check_done=0, check_match=0, id_q=0, ts_q=0, pass_count=0, state=IDLE.
- Edges below are rising edges sampled with reset_n=1.
- With RD_LATENCY=L, one pass takes 4+2L edges:
  - sysid_read is high during edge 2 (address 0) and edge 3+L (address 1).
  - check_done rises after edge 4+2L.
- Restart: the write is accepted at edge N, the FSM is in IDLE after N, and sysid_read goes high after N+1.
- Flags update at COMPARE exit. They never glitch between passes except on restart.

## Configuration
- SYSID_CHECKER_RETRY_EN defined:
  - On a mismatch in COMPARE, while retries used < MAX_RETRY, the FSM returns to RD_ID. check_done stays 0.
  - The verdict is final on the first match or after MAX_RETRY+1 passes.
- Not defined: the first COMPARE is always final, and MAX_RETRY is ignored.

## Structure
- Shared package sysid_checker_pkg holds:
  - the state enum;
  - CSR address constants (CSR_STATUS=0, CSR_ID=1, CSR_TS=2, CSR_CTRL=3);
  - status bit positions.
- One sub-module, sysid_checker_csr: CSR decode and registered readdata, restart pulse generation.

## Test plan
- Slave model returns 0 / 1363592293, RD_LATENCY=0 -> check_done=1, check_match=1 after edge 4, status reads 0x7, pass_count=1.
- Slave returns 0x00000005 for ID -> id_ok=0, ts_ok=1, check_match=0, status=0x5, CSR address 1 reads 5.
- RD_LATENCY=2, slave model delayed two cycles -> correct capture, check_done after edge 8.
- Restart write during busy -> ignored. Restart write in DONE -> flags clear, second pass runs, pass_count=2.
- reset_n pulled low mid-WAIT_TS -> all outputs at reset values next edge, full check reruns after release.
- With SYSID_CHECKER_RETRY_EN, MAX_RETRY=3, slave wrong on passes 1–2 and correct on pass 3 -> check_match=1, pass_count=3. Slave always wrong -> final after 4 passes, check_match=0.
